// File: rtl/dilithium_pkg.sv
// Shared constants for the Dilithium serialisation path: frame size, per-encoder
// packing modes and the packer FSM state type.
package dilithium_pkg;

    localparam int unsigned N = 256;

    typedef struct packed {
        logic [31:0] coeff_w;
        logic        sub_en;
        logic [31:0] offset;
    } pack_mode_t;

    // (coeff_w, sub_en, offset) per encoder; offsets are ETA, 2^(D-1) and GAMMA1.
    localparam pack_mode_t MODE_T1    = '{coeff_w: 32'd10, sub_en: 1'b0, offset: 32'd0};
    localparam pack_mode_t MODE_T0    = '{coeff_w: 32'd13, sub_en: 1'b1, offset: 32'd4096};
    localparam pack_mode_t MODE_ETA2  = '{coeff_w: 32'd3,  sub_en: 1'b1, offset: 32'd2};
    localparam pack_mode_t MODE_ETA4  = '{coeff_w: 32'd4,  sub_en: 1'b1, offset: 32'd4};
    localparam pack_mode_t MODE_Z17   = '{coeff_w: 32'd18, sub_en: 1'b1, offset: 32'd131072};
    localparam pack_mode_t MODE_Z19   = '{coeff_w: 32'd20, sub_en: 1'b1, offset: 32'd524288};
    localparam pack_mode_t MODE_W1_88 = '{coeff_w: 32'd6,  sub_en: 1'b0, offset: 32'd0};
    localparam pack_mode_t MODE_W1_32 = '{coeff_w: 32'd4,  sub_en: 1'b0, offset: 32'd0};

    typedef enum logic {
        StRun,
        StDrain
    } pack_state_e;

endpackage

// File: rtl/coeff_offset_chk.sv
// Combinational front end of the packer: optional OFFSET - a, field extraction
// and a flag for values that do not fit in COEFF_W bits.
module coeff_offset_chk #(
    parameter int unsigned COEFF_W = 10,
    parameter bit          SUB_EN  = 1'b0,
    parameter logic [31:0] OFFSET  = 32'd0
) (
    input  logic [31:0]        coeff,
    output logic [COEFF_W-1:0] field,
    output logic               out_of_range
);

    logic [31:0] v;

    always_comb begin
        v = SUB_EN ? (OFFSET - coeff) : coeff;
    end

    assign field        = v[COEFF_W-1:0];
    assign out_of_range = |v[31:COEFF_W];

endmodule

// File: rtl/poly_pack_stream.sv
// Streaming polynomial bit-packer: concatenates the low COEFF_W bits of each
// coefficient LSB-first and emits the stream as OUT_W-bit words, one frame per N.
module poly_pack_stream #(
    parameter int unsigned N       = dilithium_pkg::N,
    parameter int unsigned COEFF_W = 10,
    parameter int unsigned OUT_W   = 8,
    parameter bit          SUB_EN  = 1'b0,
    parameter logic [31:0] OFFSET  = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_coeff,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             range_err
);
    import dilithium_pkg::*;

    localparam int unsigned ACC_W  = OUT_W + COEFF_W - 1;
    localparam int unsigned FILL_W = $clog2(OUT_W + COEFF_W);
    localparam int unsigned WORDS  = N * COEFF_W / OUT_W;
    localparam int unsigned CIN_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WOUT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if (COEFF_W < 3 || COEFF_W > 20 || ((N * COEFF_W) % OUT_W) != 0) begin : g_param_err
        $error("poly_pack_stream: illegal COEFF_W/OUT_W/N combination");
    end

    pack_state_e        state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CIN_W-1:0]   cin_q, cin_d;
    logic [WOUT_W-1:0]  wout_q, wout_d;
    logic               range_err_q, range_err_d;

    logic [COEFF_W-1:0] field;
    logic               out_of_range;
    logic               in_fire, out_fire, last_word;

    coeff_offset_chk #(
        .COEFF_W (COEFF_W),
        .SUB_EN  (SUB_EN),
        .OFFSET  (OFFSET)
    ) u_coeff_offset_chk (
        .coeff        (in_coeff),
        .field        (field),
        .out_of_range (out_of_range)
    );

    // Outputs depend only on registered state; accept-in and accept-out are
    // mutually exclusive because they test opposite sides of fill vs OUT_W.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        fill_d      = fill_q;
        cin_d       = cin_q;
        wout_d      = wout_q;
        range_err_d = range_err_q;

        in_ready  = (state_q == StRun) && (fill_q < FILL_W'(OUT_W));
        out_valid = (fill_q >= FILL_W'(OUT_W));
        out_data  = acc_q[OUT_W-1:0];
        last_word = (wout_q == WOUT_W'(WORDS - 1));
        out_last  = out_valid && last_word;
        range_err = range_err_q;

        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;

        if (in_fire) begin
            acc_d       = acc_q | (ACC_W'(field) << fill_q);
            fill_d      = fill_q + FILL_W'(COEFF_W);
            cin_d       = cin_q + 1'b1;
            range_err_d = range_err_q | out_of_range;
            if (cin_q == CIN_W'(N - 1)) begin
                state_d = StDrain;
            end
        end

        if (out_fire) begin
            if (last_word) begin
                state_d = StRun;
                acc_d   = '0;
                fill_d  = '0;
                cin_d   = '0;
                wout_d  = '0;
            end else begin
                acc_d  = acc_q >> OUT_W;
                fill_d = fill_q - FILL_W'(OUT_W);
                wout_d = wout_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            acc_q       <= '0;
            fill_q      <= '0;
            cin_q       <= '0;
            wout_q      <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            cin_q       <= cin_d;
            wout_q      <= wout_d;
            range_err_q <= range_err_d;
        end
    end

endmodule

// File: tb/tb_poly_pack_stream.sv
// Bench for poly_pack_stream: T1/8-bit, eta/32-bit and z/64-bit instances checked
// against a scoreboard of expected words built as each stimulus step is issued.
module tb_poly_pack_stream;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t q_t1[$];
    exp_t q_eta[$];
    exp_t q_z[$];

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        t1_in_valid = 1'b0, t1_in_ready, t1_out_valid, t1_out_ready = 1'b1;
    logic [31:0] t1_in_coeff = '0;
    logic [7:0]  t1_out_data;
    logic        t1_out_last, t1_range_err;

    logic        eta_in_valid = 1'b0, eta_in_ready, eta_out_valid, eta_out_ready = 1'b1;
    logic [31:0] eta_in_coeff = '0;
    logic [31:0] eta_out_data;
    logic        eta_out_last, eta_range_err;

    logic        z_in_valid = 1'b0, z_in_ready, z_out_valid, z_out_ready = 1'b1;
    logic [31:0] z_in_coeff = '0;
    logic [63:0] z_out_data;
    logic        z_out_last, z_range_err;
    bit          z_stall = 1'b0;

    poly_pack_stream #(
        .N(256), .COEFF_W(10), .OUT_W(8), .SUB_EN(1'b0), .OFFSET(32'd0)
    ) u_t1 (
        .clk(clk), .rst(rst), .in_valid(t1_in_valid), .in_ready(t1_in_ready),
        .in_coeff(t1_in_coeff), .out_valid(t1_out_valid), .out_ready(t1_out_ready),
        .out_data(t1_out_data), .out_last(t1_out_last), .range_err(t1_range_err)
    );

    poly_pack_stream #(
        .N(256), .COEFF_W(3), .OUT_W(32), .SUB_EN(1'b1), .OFFSET(32'd2)
    ) u_eta (
        .clk(clk), .rst(rst), .in_valid(eta_in_valid), .in_ready(eta_in_ready),
        .in_coeff(eta_in_coeff), .out_valid(eta_out_valid), .out_ready(eta_out_ready),
        .out_data(eta_out_data), .out_last(eta_out_last), .range_err(eta_range_err)
    );

    poly_pack_stream #(
        .N(256), .COEFF_W(20), .OUT_W(64), .SUB_EN(1'b1), .OFFSET(32'd131072)
    ) u_z (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_coeff(z_in_coeff), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .out_data(z_out_data), .out_last(z_out_last), .range_err(z_range_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [63:0] data, input logic last);
        exp_t e;
        e.data = data;
        e.last = last;
        case (d)
            0:       q_t1.push_back(e);
            1:       q_eta.push_back(e);
            default: q_z.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q_t1.size();
            1:       return q_eta.size();
            default: return q_z.size();
        endcase
    endfunction

    function automatic logic ready_of(input int d);
        case (d)
            0:       return t1_in_ready;
            1:       return eta_in_ready;
            default: return z_in_ready;
        endcase
    endfunction

    // polyt1_pack byte j of a group of four 10-bit coefficients
    function automatic logic [7:0] t1_byte(input int a0, input int a1, input int a2,
                                           input int a3, input int j);
        case (j)
            0:       return 8'(a0);
            1:       return 8'((a0 >> 8) | (a1 << 2));
            2:       return 8'((a1 >> 6) | (a2 << 4));
            3:       return 8'((a2 >> 4) | (a3 << 6));
            default: return 8'(a3 >> 2);
        endcase
    endfunction

    // Called at posedge+1; holds valid until the coefficient is taken.
    task automatic send(input int d, input logic [31:0] c);
        logic rdy;
        bit   done;
        done = 1'b0;
        case (d)
            0:       begin t1_in_valid = 1'b1;  t1_in_coeff = c;  end
            1:       begin eta_in_valid = 1'b1; eta_in_coeff = c; end
            default: begin z_in_valid = 1'b1;   z_in_coeff = c;   end
        endcase
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            rdy = ready_of(d);
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        t1_in_valid  = 1'b0;
        eta_in_valid = 1'b0;
        z_in_valid   = 1'b0;
        if (!done) check("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic wait_drain(input int d, input string tag);
        for (int cyc = 0; cyc < 3000 && qsize(d) != 0; cyc++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check(tag, 64'(qsize(d)), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && t1_out_valid) begin
            if (q_t1.size() == 0) check("t1_spurious_word", 64'(t1_out_valid), 64'd0);
            else begin
                check("t1_data", 64'(t1_out_data), q_t1[0].data);
                check("t1_last", 64'(t1_out_last), 64'(q_t1[0].last));
                if (t1_out_ready) void'(q_t1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && eta_out_valid) begin
            if (q_eta.size() == 0) check("eta_spurious_word", 64'(eta_out_valid), 64'd0);
            else begin
                check("eta_data", 64'(eta_out_data), q_eta[0].data);
                check("eta_last", 64'(eta_out_last), 64'(q_eta[0].last));
                if (eta_out_ready) void'(q_eta.pop_front());
            end
        end
    end

    // Comparing against the head entry on every valid cycle also proves stall stability.
    always @(negedge clk) begin
        if (!rst && z_out_valid) begin
            if (q_z.size() == 0) check("z_spurious_word", 64'(z_out_valid), 64'd0);
            else begin
                check("z_data", z_out_data, q_z[0].data);
                check("z_last", 64'(z_out_last), 64'(q_z[0].last));
                if (z_out_ready) void'(q_z.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (z_stall) z_out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int          t1_a[256];
        int          r[100];
        logic [19:0] zf[256];
        logic [7:0]  dir_bytes[5];
        logic [7:0]  rng_bytes[5];
        logic [31:0] eta_pat[3];
        logic [63:0] w;
        int          pos;
        int          nw;

        dir_bytes = '{8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA};
        rng_bytes = '{8'h00, 8'h04, 8'h20, 8'hC0, 8'h00};
        eta_pat   = '{32'h24924924, 32'h49249249, 32'h92492492};

        repeat (2) @(posedge clk);
        #1;
        check("rst_t1_in_ready", 64'(t1_in_ready), 64'd1);
        check("rst_t1_out_valid", 64'(t1_out_valid), 64'd0);
        check("rst_t1_out_data", 64'(t1_out_data), 64'd0);
        check("rst_t1_out_last", 64'(t1_out_last), 64'd0);
        check("rst_t1_range_err", 64'(t1_range_err), 64'd0);
        check("rst_eta_in_ready", 64'(eta_in_ready), 64'd1);
        check("rst_z_out_valid", 64'(z_out_valid), 64'd0);
        rst = 1'b0;

        // T1 frame: directed first group, then random, against polyt1_pack.
        t1_a[0] = 32'h3FF; t1_a[1] = 0; t1_a[2] = 32'h155; t1_a[3] = 32'h2AA;
        for (int i = 4; i < 256; i++) t1_a[i] = int'($urandom_range(0, 1023));
        for (int j = 0; j < 5; j++) push(0, 64'(dir_bytes[j]), 1'b0);
        for (int g = 1; g < 64; g++) begin
            for (int j = 0; j < 5; j++) begin
                push(0, 64'(t1_byte(t1_a[4*g], t1_a[4*g+1], t1_a[4*g+2], t1_a[4*g+3], j)),
                     (5 * g + j) == 319);
            end
        end
        send(0, 32'(t1_a[0]));
        check("t1_in_ready_pending", 64'(t1_in_ready), 64'd0);
        check("t1_out_valid_pending", 64'(t1_out_valid), 64'd1);
        for (int i = 1; i < 256; i++) send(0, 32'(t1_a[i]));
        wait_drain(0, "t1_frame_drain");
        check("t1_in_ready_after_frame", 64'(t1_in_ready), 64'd1);
        check("t1_out_valid_after_frame", 64'(t1_out_valid), 64'd0);

        // Eta: all -2 packs field 4, a 96-bit repeating pattern.
        for (int k = 0; k < 24; k++) push(1, 64'(eta_pat[k % 3]), k == 23);
        for (int i = 0; i < 256; i++) send(1, 32'hFFFF_FFFE);
        wait_drain(1, "eta_frame_drain");
        check("eta_in_ready_after_frame", 64'(eta_in_ready), 64'd1);
        check("eta_range_err", 64'(eta_range_err), 64'd0);

        // Z: bit-serial model, once with no stall and once with random out_ready.
        for (int i = 0; i < 256; i++) zf[i] = 20'($urandom_range(0, 20'hFFFFF));
        for (int pass = 0; pass < 2; pass++) begin
            w = '0; pos = 0; nw = 0;
            for (int i = 0; i < 256; i++) begin
                for (int b = 0; b < 20; b++) begin
                    w[pos] = zf[i][b];
                    pos++;
                    if (pos == 64) begin
                        push(2, w, nw == 79);
                        nw++;
                        pos = 0;
                        w = '0;
                    end
                end
            end
            z_stall = (pass == 1);
            for (int i = 0; i < 256; i++) send(2, 32'd131072 - 32'(zf[i]));
            wait_drain(2, pass == 0 ? "z_frame_drain" : "z_stall_frame_drain");
            z_stall = 1'b0;
            z_out_ready = 1'b1;
            check("z_range_err", 64'(z_range_err), 64'd0);
        end

        // Range error on 0x400 (field 0 still packed), then reset mid-frame.
        r[0] = 32'h400; r[1] = 1; r[2] = 2; r[3] = 3;
        for (int i = 4; i < 100; i++) r[i] = int'($urandom_range(0, 1023));
        for (int j = 0; j < 5; j++) push(0, 64'(rng_bytes[j]), 1'b0);
        for (int g = 1; g < 25; g++) begin
            for (int j = 0; j < 5; j++) begin
                push(0, 64'(t1_byte(r[4*g], r[4*g+1], r[4*g+2], r[4*g+3], j)), 1'b0);
            end
        end
        check("range_err_before", 64'(t1_range_err), 64'd0);
        send(0, 32'(r[0]));
        check("range_err_rise", 64'(t1_range_err), 64'd1);
        for (int i = 1; i < 99; i++) send(0, 32'(r[i]));
        check("range_err_sticky", 64'(t1_range_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        t1_out_ready = 1'b0;
        send(0, 32'(r[99]));
        repeat (2) @(posedge clk);
        #1;
        check("stalled_out_valid", 64'(t1_out_valid), 64'd1);
        rst = 1'b1;
        q_t1.delete();
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 64'(t1_in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(t1_out_valid), 64'd0);
        check("mid_rst_out_data", 64'(t1_out_data), 64'd0);
        check("mid_rst_out_last", 64'(t1_out_last), 64'd0);
        check("mid_rst_range_err", 64'(t1_range_err), 64'd0);
        rst = 1'b0;
        t1_out_ready = 1'b1;

        for (int j = 0; j < 5; j++) push(0, 64'(dir_bytes[j]), 1'b0);
        for (int i = 0; i < 4; i++) send(0, 32'(t1_a[i]));
        wait_drain(0, "fresh_frame_drain");
        check("fresh_out_valid", 64'(t1_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
